uart_tx_arbiter: RTL and testbench

- Shares a single uart_tx transmitter between N requesters using round-robin arbitration with packet locking.
- Each requester presents bytes over a valid/ready handshake. The arbiter captures one byte, pulses tx_start, and tracks tx_busy until the frame completes.
- An inter-byte gap is counted in baud ticks.
- Sits between client logic (key-triggered senders, echo path, status reporter) and the uart_tx instance, sharing the baud_tick of the top-level generator.

---
 rtl/uart_tx_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between N byte requesters.
// Round-robin grant with packet locking. A granted byte is captured, tx_start
// is pulsed, and the frame is tracked via tx_busy. An idle gap of GAP_TICKS
// baud ticks follows each frame before the next byte may start.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   req_valid[N]    per-requester byte valid
//   req_data[8N]    per-requester byte, requester i on [8i+7:8i]
//   req_last[N]     byte ends a packet (releases the lock when accepted)
//   req_ready[N]    one-hot accept strobe, only in ACCEPT
//   baud_tick       one-clk pulse per bit period (shared with uart_tx)
//   tx_busy         busy output of uart_tx
//   tx_start        one-clk start pulse to uart_tx
//   tx_data[8]      byte to uart_tx, held until the next capture
//   owner[3]        current/last granted requester
//   locked          a packet lock is held by owner
//   start_err       sticky: tx_busy failed to rise within BUSY_WAIT clks
module uart_tx_arbiter #(
  parameter int N            = 4,
  parameter int GAP_TICKS    = 1,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int BUSY_WAIT    = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  input  logic           baud_tick,
  input  logic           tx_busy,
  output logic           tx_start,
  output logic [7:0]     tx_data,
  output logic [2:0]     owner,
  output logic           locked,
  output logic           start_err
);

  typedef enum logic [2:0] {IDLE, ACCEPT, START, WAIT_HI, WAIT_LO, GAP} state_t;

  // Counter widths are kept at least 1 bit so a zero parameter stays legal.
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int WW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT + 1) : 1;
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  state_t        state, state_next;
  logic [GW-1:0] gap_cnt;
  logic [WW-1:0] wait_cnt;
  logic [TW-1:0] to_cnt;

  logic          sel_valid, sel_last;
  logic [7:0]    sel_data;
  logic          found;
  logic [2:0]    pick;
  logic          wait_done;

  // Mux of the current owner's request lines.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (i == int'(owner)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  // Round-robin search starting one past the last owner; first hit wins.
  always_comb begin
    found = 1'b0;
    pick  = owner;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req_valid[i] && (i == (int'(owner) + k) % N)) begin
          found = 1'b1;
          pick  = 3'(i);
        end
      end
    end
  end

  assign wait_done = (wait_cnt >= WW'(BUSY_WAIT - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and strobes.
  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (locked) begin
          if (sel_valid) state_next = ACCEPT;
        end else if (found) begin
          state_next = ACCEPT;
        end
      end
      ACCEPT: begin
        req_ready  = {{(N-1){1'b0}}, 1'b1} << owner;
        // A requester that withdrew before acceptance gets nothing sent.
        state_next = sel_valid ? START : IDLE;
      end
      START: begin
        tx_start   = 1'b1;
        state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy)        state_next = WAIT_LO;
        else if (wait_done) state_next = GAP;
      end
      WAIT_LO: if (!tx_busy) state_next = GAP;
      GAP:     if (gap_cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: owner, captured byte, lock and the three counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= 3'(N - 1);
      tx_data   <= 8'h00;
      locked    <= 1'b0;
      start_err <= 1'b0;
      gap_cnt   <= '0;
      wait_cnt  <= '0;
      to_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (locked) begin
            // The lock timeout only runs while the owner has nothing pending.
            if (sel_valid) begin
              to_cnt <= '0;
            end else if (to_cnt == TW'(LOCK_TIMEOUT - 1)) begin
              locked <= 1'b0;
              to_cnt <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end else begin
            to_cnt <= '0;
            if (found) owner <= pick;
          end
        end
        ACCEPT: begin
          if (sel_valid) begin
            tx_data <= sel_data;
            locked  <= ~sel_last;
          end
        end
        START: wait_cnt <= '0;
        WAIT_HI: begin
          if (!tx_busy) begin
            if (wait_done) begin
              start_err <= 1'b1;
              gap_cnt   <= GW'(GAP_TICKS);
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        WAIT_LO: if (!tx_busy) gap_cnt <= GW'(GAP_TICKS);
        GAP:     if (baud_tick && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed steps in one initial block, a
// behavioural uart_tx model that pops a scoreboard of expected bytes on every
// tx_start, and per-requester byte queues that follow the valid/ready rules.
module tb_uart_tx_arbiter;

  localparam int N      = 4;
  localparam int GAP    = 3;
  localparam int LT     = 100;
  localparam int BW     = 15;
  localparam int FRAME  = 10;    // baud ticks per uart frame in the model
  localparam int BUDGET = 2000;  // clk cycles allowed per run() call

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           baud_tick = 1'b0;
  logic           tx_busy = 1'b0;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic [2:0]     owner;
  logic           locked;
  logic           start_err;

  uart_tx_arbiter #(
    .N(N), .GAP_TICKS(GAP), .LOCK_TIMEOUT(LT), .BUSY_WAIT(BW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .baud_tick(baud_tick), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data),
    .owner(owner), .locked(locked), .start_err(start_err)
  );

  always #5 clk = ~clk;

  int tick_div = 0;
  always begin
    @(posedge clk);
    #1;
    tick_div  = (tick_div + 1) % 4;
    baud_tick = (tick_div == 0);
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard entry: byte, owner and lock state expected at tx_start, plus an
  // optional window (clk cycles since the previous frame ended) when hi > 0.
  typedef struct {
    logic [7:0] data;
    logic [2:0] own;
    logic       lck;
    int         lo;
    int         hi;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] rq[N][$];   // {last, data} per requester
  int         dead_cnt = 0;

  function automatic void sb_add(input logic [7:0] d, input logic [2:0] o,
                                 input logic l, input int lo, input int hi);
    exp_t e;
    e.data = d; e.own = o; e.lck = l; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endfunction

  // uart_tx model and output checker, evaluated on the falling edge.
  int         since_fall = 0;
  int         ticks_since = 0;
  bit         have_fall = 0;
  int         ticks_left = 0;
  bit         err_watch = 0;
  int         err_cnt = 0;
  logic [7:0] cap = 8'h00;

  always begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      tx_busy   = 1'b0;
      err_watch = 0;
      have_fall = 0;
    end else begin
      since_fall++;
      if (baud_tick) ticks_since++;
      if (err_watch) begin
        err_cnt++;
        if (err_cnt == BW) check("start_err_early", 32'(start_err), 0);
        else if (err_cnt == BW + 1) begin
          check("start_err_set", 32'(start_err), 1);
          err_watch = 0;
        end
      end
      if (tx_start) begin
        if (sb.size() == 0) begin
          check("spurious_tx_start", 32'(tx_start), 0);
        end else begin
          e = sb.pop_front();
          check("tx_data", 32'(tx_data), 32'(e.data));
          check("owner", 32'(owner), 32'(e.own));
          check("locked", 32'(locked), 32'(e.lck));
          if (e.hi > 0)
            check("lock_release_window", 32'(since_fall >= e.lo && since_fall <= e.hi), 1);
          if (have_fall) check("gap_ticks_min", 32'(ticks_since >= GAP), 1);
        end
        cap = tx_data;
        if (dead_cnt > 0) begin
          dead_cnt--;
          err_watch = 1;
          err_cnt   = 0;
        end else begin
          tx_busy    = 1'b1;
          ticks_left = FRAME;
        end
      end else if (tx_busy && baud_tick) begin
        ticks_left--;
        if (ticks_left == 0) begin
          check("tx_data_stable", 32'(tx_data), 32'(cap));
          tx_busy     = 1'b0;
          have_fall   = 1;
          since_fall  = 0;
          ticks_since = 0;
        end
      end
    end
  end

  // Present queued bytes until drained (or until a frame is in flight when
  // stop_busy is set). Requesters in 'late' stay silent for late_cyc cycles.
  task automatic run(input logic [N-1:0] late, input int late_cyc, input bit stop_busy);
    int         cyc;
    bit         pending;
    bit         done;
    logic [N-1:0] acc;
    cyc = 0;
    forever begin
      pending = 0;
      for (int i = 0; i < N; i++) begin
        if (rq[i].size() > 0) begin
          pending            = 1;
          req_valid[i]       = !(late[i] && cyc < late_cyc);
          req_data[8*i +: 8] = rq[i][0][7:0];
          req_last[i]        = rq[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      done = stop_busy ? (!pending && tx_busy) : (!pending && sb.size() == 0 && !tx_busy);
      if (done) break;
      if (cyc > BUDGET) begin
        check("run_timeout", 32'(cyc), 32'(BUDGET));
        break;
      end
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++)
        if (acc[i]) void'(rq[i].pop_front());
    end
    if (!stop_busy) repeat (30) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0;

    // Reset state.
    @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_owner", 32'(owner), N - 1);
    check("rst_locked", 32'(locked), 0);
    check("rst_start_err", 32'(start_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // All four request at once: served 0,1,2,3.
    rq[0].push_back({1'b1, 8'h11}); rq[1].push_back({1'b1, 8'h22});
    rq[2].push_back({1'b1, 8'h33}); rq[3].push_back({1'b1, 8'h44});
    sb_add(8'h11, 0, 0, 0, 0); sb_add(8'h22, 1, 0, 0, 0);
    sb_add(8'h33, 2, 0, 0, 0); sb_add(8'h44, 3, 0, 0, 0);
    run('0, 0, 0);

    // Second round with requesters 1 and 3 only.
    rq[1].push_back({1'b1, 8'h22}); rq[3].push_back({1'b1, 8'h44});
    sb_add(8'h22, 1, 0, 0, 0); sb_add(8'h44, 3, 0, 0, 0);
    run('0, 0, 0);

    // Single requester: ready on the cycle after grant, tx_start one later.
    sb_add(8'hB3, 0, 0, 0, 0);
    req_valid[0] = 1'b1; req_data[7:0] = 8'hB3; req_last[0] = 1'b1;
    @(negedge clk);
    check("lat_ready_grant_cycle", 32'(req_ready), 0);
    check("lat_start_grant_cycle", 32'(tx_start), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_ready_accept", 32'(req_ready), 1);
    check("lat_start_accept", 32'(tx_start), 0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("lat_start_pulse", 32'(tx_start), 1);
    check("lat_ready_after", 32'(req_ready), 0);
    @(posedge clk); #1;
    run('0, 0, 0);

    // Requester 2 sends a locked 3-byte packet; requester 0 arrives later.
    rq[2].push_back({1'b0, 8'hA0}); rq[2].push_back({1'b0, 8'hA1});
    rq[2].push_back({1'b1, 8'hA2}); rq[0].push_back({1'b1, 8'h55});
    sb_add(8'hA0, 2, 1, 0, 0); sb_add(8'hA1, 2, 1, 0, 0);
    sb_add(8'hA2, 2, 0, 0, 0); sb_add(8'h55, 0, 0, 0, 0);
    run(4'b0001, 2, 0);

    // Owner 0 locks and goes silent; requester 1 waits for the timeout.
    rq[0].push_back({1'b0, 8'h66}); rq[1].push_back({1'b1, 8'h77});
    sb_add(8'h66, 0, 1, 0, 0);
    sb_add(8'h77, 1, 0, LT, LT + 40);
    run(4'b0010, 2, 0);
    check("lock_cleared", 32'(locked), 0);

    // uart_tx never goes busy for one byte: start_err, then the next byte.
    dead_cnt = 1;
    rq[2].push_back({1'b1, 8'h88}); rq[3].push_back({1'b1, 8'h99});
    sb_add(8'h88, 2, 0, 0, 0); sb_add(8'h99, 3, 0, 0, 0);
    run('0, 0, 0);
    check("start_err_sticky", 32'(start_err), 1);

    // Reset in the middle of a frame (WAIT_LO).
    rq[1].push_back({1'b1, 8'h5A});
    sb_add(8'h5A, 1, 0, 0, 0);
    run('0, 0, 1);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_tx_start", 32'(tx_start), 0);
    check("mid_rst_req_ready", 32'(req_ready), 0);
    check("mid_rst_tx_data", 32'(tx_data), 0);
    check("mid_rst_owner", 32'(owner), N - 1);
    check("mid_rst_locked", 32'(locked), 0);
    check("mid_rst_start_err", 32'(start_err), 0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // After reset the search restarts at requester 0.
    rq[0].push_back({1'b1, 8'hC0}); rq[2].push_back({1'b1, 8'hC2});
    sb_add(8'hC0, 0, 0, 0, 0); sb_add(8'hC2, 2, 0, 0, 0);
    run('0, 0, 0);
    check("sb_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
